// File: rtl/adding_bytes.sv
// adding_bytes: registered WIDTH-bit ripple-carry adder with carry-in.
//
// {cout, out} is loaded every rising clk edge with in0 + in1 + i, computed by a
// chain of WIDTH full-adder cells. Each cell is built from two half adders and an OR gate.
// Reset is asynchronous and active-high, and it clears both outputs immediately.
//
// Ports:
//   clk  - clock; all state changes on its rising edge
//   rst  - asynchronous active-high reset
//   i    - carry-in into bit 0
//   in0  - first unsigned operand  [WIDTH-1:0]
//   in1  - second unsigned operand [WIDTH-1:0]
//   out  - registered sum bits     [WIDTH-1:0]
//   cout - registered carry out of bit WIDTH-1
module adding_bytes #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    // w_carry[k] is the carry into cell k; w_carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_prop;   // first half adder sum: a ^ b
    logic [WIDTH-1:0] w_gen;    // first half adder carry: a & b
    logic [WIDTH-1:0] w_sum;    // second half adder sum: a ^ b ^ c
    logic [WIDTH-1:0] w_pcarry; // second half adder carry: c & (a ^ b)

    logic [WIDTH-1:0] r_out;
    logic             r_cout;

    assign w_carry[0] = i;

    for (genvar k = 0; k < WIDTH; k++) begin : g_fa
        assign w_prop[k]      = in0[k] ^ in1[k];
        assign w_gen[k]       = in0[k] & in1[k];
        assign w_sum[k]       = w_prop[k] ^ w_carry[k];
        assign w_pcarry[k]    = w_carry[k] & w_prop[k];
        assign w_carry[k + 1] = w_gen[k] | w_pcarry[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_out  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign out  = r_out;
    assign cout = r_cout;

endmodule

// File: tb/tb_adding_bytes.sv
// Self-checking bench for adding_bytes (WIDTH = 8).
// The expected result is the plain 9-bit arithmetic sum of the inputs at the capturing edge.
module tb_adding_bytes;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         i;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic [W-1:0] out;
    logic         cout;

    int errors = 0;
    int checks = 0;

    adding_bytes #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .i    (i),
        .in0  (in0),
        .in1  (in1),
        .out  (out),
        .cout (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
        int unsigned s;
        s = int'(a) + int'(b) + int'(c);
        return s[W:0];
    endfunction

    // Drive inputs at the falling edge, then stop 1 time unit after the next rising edge.
    task automatic drive_and_clock(input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        i   = c;
        in0 = a;
        in1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({cout, out} !== 9'h000) begin
            errors++;
            $display("FAIL reset_async: got %h expected 000", {cout, out});
        end
        // A rising edge while rst is high must leave the outputs cleared.
        @(posedge clk);
        #1;
        checks++;
        if ({cout, out} !== 9'h000) begin
            errors++;
            $display("FAIL reset_edge: got %h expected 000", {cout, out});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W:0] exp_v;
        logic         c_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] a_tab [6] = '{8'h01, 8'h01, 8'h05, 8'h08, 8'hFF, 8'hFF};
        logic [W-1:0] b_tab [6] = '{8'h01, 8'h02, 8'h10, 8'h08, 8'hFF, 8'h00};
        logic [W:0]   r_tab [6] = '{9'h002, 9'h003, 9'h015, 9'h010, 9'h1FE, 9'h100};
        for (int n = 0; n < 6; n++) begin
            drive_and_clock(c_tab[n], a_tab[n], b_tab[n]);
            exp_v = model(c_tab[n] ? a_tab[n] : a_tab[n], b_tab[n], c_tab[n]);
            checks++;
            if ({cout, out} !== r_tab[n] || r_tab[n] !== exp_v) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", n, {cout, out}, r_tab[n]);
            end
        end
        // Extremes of the operand range.
        drive_and_clock(1'b1, 8'hFF, 8'hFF);
        checks++;
        if ({cout, out} !== 9'h1FF) begin
            errors++;
            $display("FAIL max_case: got %h expected 1ff", {cout, out});
        end
        drive_and_clock(1'b0, 8'h00, 8'h00);
        checks++;
        if ({cout, out} !== 9'h000) begin
            errors++;
            $display("FAIL min_case: got %h expected 000", {cout, out});
        end
    endtask

    task automatic test_midcycle();
        drive_and_clock(1'b0, 8'h3C, 8'h42);
        checks++;
        if ({cout, out} !== 9'h07E) begin
            errors++;
            $display("FAIL mid_first: got %h expected 07e", {cout, out});
        end
        // Change inputs just after the edge; the outputs must hold until the next edge.
        i   = 1'b1;
        in0 = 8'hC8;
        in1 = 8'h77;
        #2;
        checks++;
        if ({cout, out} !== 9'h07E) begin
            errors++;
            $display("FAIL mid_hold: got %h expected 07e", {cout, out});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout, out} !== model(8'hC8, 8'h77, 1'b1)) begin
            errors++;
            $display("FAIL mid_update: got %h expected %h", {cout, out},
                     model(8'hC8, 8'h77, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        drive_and_clock(1'b0, 8'hFF, 8'hFF);
        checks++;
        if ({cout, out} !== 9'h1FE) begin
            errors++;
            $display("FAIL rmid_load: got %h expected 1fe", {cout, out});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cout, out} !== 9'h000) begin
            errors++;
            $display("FAIL rmid_async: got %h expected 000", {cout, out});
        end
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({cout, out} !== 9'h000) begin
                errors++;
                $display("FAIL rmid_hold_%0d: got %h expected 000", n, {cout, out});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        i   = 1'b1;
        in0 = 8'h80;
        in1 = 8'h7F;
        @(posedge clk);
        #1;
        checks++;
        if ({cout, out} !== 9'h100) begin
            errors++;
            $display("FAIL rmid_release: got %h expected 100", {cout, out});
        end
    endtask

    task automatic test_random();
        logic         c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp_v;
        for (int n = 0; n < 1200; n++) begin
            c = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            drive_and_clock(c, a, b);
            exp_v = model(a, b, c);
            checks++;
            if ({cout, out} !== exp_v) begin
                errors++;
                $display("FAIL random_%0d: in %h+%h+%b got %h expected %h", n, a, b, c,
                         {cout, out}, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i   = 1'b1;
        in0 = 8'h5A;
        in1 = 8'hA7;
        test_reset();
        test_directed();
        test_midcycle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adding_bytes.md
ADDING_BYTES -- requirements
Module: adding_bytes

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; all values below assume WIDTH=8.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1, reset, asynchronous, active-high.
REQ-004 Port: i, input, 1, carry-in added at bit 0.
REQ-005 Port: in0, input, WIDTH, first unsigned operand.
REQ-006 Port: in1, input, WIDTH, second unsigned operand.
REQ-007 Port: out, output, WIDTH, registered sum bits [WIDTH-1:0].
REQ-008 Port: cout, output, 1, registered carry-out from bit WIDTH-1.

Function
REQ-009 The block SHALL compute {cout,out} = in0 + in1 + i as a WIDTH+1-bit unsigned result; no truncation except the split into out and cout.
REQ-010 The adder datapath SHALL be a ripple-carry chain of WIDTH full-adder cells, each built from half-adder and gate primitives (XOR/AND/OR), carry of cell k feeding cell k+1, i feeding cell 0.
REQ-011 The full-adder cell SHALL produce s = a^b^c and co = (a&b)|(c&(a^b)).
REQ-012 The carry out of the last cell SHALL be the cout source; no carry-lookahead or behavioral "+" operator in the datapath.
REQ-013 out and cout SHALL be registered: on each rising clk edge with rst low, both are loaded from the combinational sum of the inputs present at that edge.
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N appear on out/cout after edge N and hold until edge N+1.
REQ-015 There is no enable or handshake; a new result is captured every cycle.
REQ-016 Wrap-around: sums >= 2^WIDTH SHALL wrap in out with cout=1 (e.g. FF+00+1 -> out=00, cout=1).
REQ-017 Maximum case FF+FF+1 SHALL give out=FF, cout=1; minimum 00+00+0 gives out=00, cout=0.
REQ-018 Input changes between clock edges SHALL not affect out/cout until the next rising edge.
REQ-019 Outputs SHALL never be X once rst has been asserted, for any known input values.

Reset
REQ-020 While rst=1, out SHALL be 00 and cout SHALL be 0, taking effect immediately without waiting for clk.
REQ-021 rst asserted mid-operation SHALL discard the pending result; the first result after release is captured on the first rising edge with rst low.
REQ-022 A rising edge coinciding with rst=1 SHALL leave outputs at reset values.

Verification
REQ-023 Scenario: i=0, in0=01, in1=01, one edge -> out=02, cout=0; then in1=02 -> out=03, cout=0.
REQ-024 Scenario: i=0, in0=05, in1=10 -> out=15, cout=0; i=0, in0=08, in1=08 -> out=10, cout=0 (carry ripples through bit 3).
REQ-025 Scenario: i=0, in0=FF, in1=FF -> out=FE, cout=1; i=1, in0=FF, in1=00 -> out=00, cout=1 (full-chain ripple).
REQ-026 Scenario: change inputs mid-cycle -> out/cout unchanged until next rising edge, then reflect inputs at that edge (one-cycle latency check).
REQ-027 Scenario: with out=FE, cout=1, assert rst between edges -> out=00, cout=0 immediately; hold through edges; release -> next edge loads current sum.
REQ-028 Scenario: randomized sweep of i/in0/in1 (at least 1000 vectors) -> {cout,out} equals in0+in1+i of the previous cycle on every edge.
